gsr_pur_assign_gen: RTL and testbench



---
 rtl/gsr_pur_pkg.sv | 9 +
 rtl/gsr_pur_assign_gen_if.sv | 11 +
 rtl/gsr_pur_sync.sv | 20 ++
 rtl/gsr_pur_assign_gen.sv | 64 ++++++
 tb/tb_gsr_pur_assign_gen.sv | 112 +++++++++++
 5 files changed

// File: rtl/gsr_pur_pkg.sv
// gsr_pur_pkg: shared defaults and counter-width helper for the GSR/PUR generator
package gsr_pur_pkg;
  localparam int PUR_CYCLES_DEF = 16;
  localparam int GSR_PULSE_DEF = 4;
  localparam int SYNC_STAGES_DEF = 2;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/gsr_pur_assign_gen_if.sv
// gsr_pur_assign_gen_if: request inputs and global reset nets of the GSR/PUR generator
interface gsr_pur_assign_gen_if;
  logic GSRN_IN;
  logic SW_GSR;
  logic PURNET;
  logic GSRNET;
  logic PUR_DONE;
  logic GSR_ACTIVE;
  modport master(output GSRN_IN, SW_GSR, input PURNET, GSRNET, PUR_DONE, GSR_ACTIVE);
  modport slave(input GSRN_IN, SW_GSR, output PURNET, GSRNET, PUR_DONE, GSR_ACTIVE);
endinterface

// File: rtl/gsr_pur_sync.sv
// gsr_pur_sync: flop-chain synchroniser that resets to the deasserted (1) level
module gsr_pur_sync
  import gsr_pur_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  if (STAGES < 2) begin : g_bad_stages
    $fatal(1, "gsr_pur_sync: STAGES must be >= 2");
  end
  always_ff @(posedge clk)
    if (rst) ff <= '1;
    else ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/gsr_pur_assign_gen.sv
// gsr_pur_assign_gen: power-up reset sequencer and stretched global set/reset for gearing cells
module gsr_pur_assign_gen
  import gsr_pur_pkg::*;
#(
  parameter int PUR_CYCLES  = PUR_CYCLES_DEF,
  parameter int GSR_PULSE   = GSR_PULSE_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int GSR_ENABLE  = 1
) (
  input logic CLK,
  input logic RST,
  gsr_pur_assign_gen_if.slave bus
);
  localparam int PW = cnt_w(PUR_CYCLES);
  localparam int SW = cnt_w(GSR_PULSE);
  localparam logic [PW-1:0] PUR_MAX = PW'(PUR_CYCLES);
  localparam logic [SW-1:0] PULSE = SW'(GSR_PULSE);
  if (PUR_CYCLES < 1) begin : g_bad_pur
    $fatal(1, "gsr_pur_assign_gen: PUR_CYCLES must be >= 1");
  end
  if (GSR_PULSE < 1) begin : g_bad_pulse
    $fatal(1, "gsr_pur_assign_gen: GSR_PULSE must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $fatal(1, "gsr_pur_assign_gen: SYNC_STAGES must be >= 2");
  end
  if (GSR_ENABLE != 0 && GSR_ENABLE != 1) begin : g_bad_en
    $fatal(1, "gsr_pur_assign_gen: GSR_ENABLE must be 0 or 1");
  end
  logic [PW-1:0] pur_cnt, pur_cnt_nxt;
  logic [SW-1:0] str_cnt, str_cnt_nxt;
  logic sync_q, gsr_req_sync, req, pur_nxt, gsr_nxt;
  gsr_pur_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(CLK),
    .rst(RST),
    .d  (bus.GSRN_IN),
    .q  (sync_q)
  );
  assign gsr_req_sync = ~sync_q;
  // requests only count once power-up has finished; the stretch counter holds the remaining low time
  always_comb begin
    pur_cnt_nxt = (pur_cnt == PUR_MAX) ? pur_cnt : pur_cnt + PW'(1);
    pur_nxt = pur_cnt_nxt == PUR_MAX;
    req = (GSR_ENABLE == 1) && bus.PUR_DONE && (bus.SW_GSR || gsr_req_sync);
    str_cnt_nxt = req ? PULSE : (str_cnt != '0) ? str_cnt - SW'(1) : str_cnt;
    gsr_nxt = pur_nxt && (str_cnt_nxt == '0) && !req;
  end
  always_ff @(posedge CLK)
    if (RST) begin
      pur_cnt <= '0;
      str_cnt <= '0;
      bus.PURNET <= 1'b0;
      bus.GSRNET <= 1'b0;
      bus.PUR_DONE <= 1'b0;
      bus.GSR_ACTIVE <= 1'b0;
    end else begin
      pur_cnt <= pur_cnt_nxt;
      str_cnt <= str_cnt_nxt;
      bus.PURNET <= pur_nxt;
      bus.GSRNET <= gsr_nxt;
      bus.PUR_DONE <= pur_nxt;
      bus.GSR_ACTIVE <= pur_nxt && !gsr_nxt;
    end
endmodule

// File: tb/tb_gsr_pur_assign_gen.sv
// tb_gsr_pur_assign_gen: vector table, directed corner sequences and random traffic against a time-based model
module tb_gsr_pur_assign_gen;
  localparam int PUR = 16;
  localparam int PULSE = 4;
  localparam int SYNC = 2;
  logic clk, rst;
  gsr_pur_assign_gen_if bus_a ();
  gsr_pur_assign_gen_if bus_b ();
  gsr_pur_assign_gen dut_a (.CLK(clk), .RST(rst), .bus(bus_a));
  gsr_pur_assign_gen #(.GSR_ENABLE(0)) dut_b (.CLK(clk), .RST(rst), .bus(bus_b));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  int t = 0, n_rel = 0, last_req = -100;
  bit m_pur, m_gsr, m_done, m_act;
  bit hist[$];
  typedef struct {
    bit sw;
    bit gsrn;
    bit exp_gsr;
    bit exp_act;
  } vec_t;
  vec_t vecs[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // model: GSRNET is low for PULSE edges counted from the latest accepted request edge
  task automatic model_edge(input bit r, input bit sw, input bit gsrn);
    bit old;
    bit rq;
    t++;
    if (r) begin
      n_rel = 0; m_pur = 0; m_gsr = 0; m_done = 0; m_act = 0; last_req = -100;
      hist = {};
      repeat (SYNC) hist.push_back(1'b1);
    end else begin
      old = hist.pop_front();
      hist.push_back(gsrn);
      rq = m_done && (sw || !old);
      if (rq) last_req = t;
      n_rel++;
      m_pur = n_rel >= PUR;
      m_done = m_pur;
      m_gsr = m_pur && (t - last_req >= PULSE);
      m_act = m_done && !m_gsr;
    end
  endtask
  task automatic cyc(input bit r, input bit sw, input bit gsrn);
    rst = r;
    bus_a.SW_GSR = sw; bus_a.GSRN_IN = gsrn;
    bus_b.SW_GSR = sw; bus_b.GSRN_IN = gsrn;
    @(posedge clk);
    model_edge(r, sw, gsrn);
    #1;
    chk("model_a", {28'd0, bus_a.PURNET, bus_a.GSRNET, bus_a.PUR_DONE, bus_a.GSR_ACTIVE},
        {28'd0, m_pur, m_gsr, m_done, m_act});
    chk("gsr_off_b", {28'd0, bus_b.PURNET, bus_b.GSRNET, bus_b.PUR_DONE, bus_b.GSR_ACTIVE},
        {28'd0, m_pur, m_pur, m_pur, 1'b0});
  endtask
  task automatic pur_seq(input int pulse_at);
    for (int i = 1; i <= PUR; i++) begin
      cyc(1'b0, i == pulse_at, 1'b1);
      if (i == PUR - 1) chk("pur_low_at_15", {30'd0, bus_a.PURNET, bus_a.GSRNET}, 32'd0);
      if (i == PUR) chk("pur_rise_at_16", {29'd0, bus_a.PURNET, bus_a.GSRNET, bus_a.PUR_DONE}, 32'd7);
    end
  endtask
  initial begin
    int fall, lowcnt;
    bit burst;
    hist = {};
    repeat (SYNC) hist.push_back(1'b1);
    vecs = '{'{1, 1, 0, 1}, '{0, 1, 0, 1}, '{0, 1, 0, 1}, '{0, 1, 0, 1}, '{0, 1, 1, 0},
             '{0, 1, 1, 0}, '{1, 1, 0, 1}, '{0, 1, 0, 1}, '{1, 1, 0, 1}, '{0, 1, 0, 1},
             '{0, 1, 0, 1}, '{0, 1, 0, 1}, '{0, 1, 1, 0}, '{0, 1, 1, 0}};
    repeat (3) cyc(1'b1, 1'b0, 1'b1);
    chk("reset_state", {28'd0, bus_a.PURNET, bus_a.GSRNET, bus_a.PUR_DONE, bus_a.GSR_ACTIVE}, 32'd0);
    pur_seq(5);
    foreach (vecs[i]) begin
      cyc(1'b0, vecs[i].sw, vecs[i].gsrn);
      chk("vec", {29'd0, bus_a.GSRNET, bus_a.GSR_ACTIVE, bus_a.PURNET},
          {29'd0, vecs[i].exp_gsr, vecs[i].exp_act, 1'b1});
    end
    fall = -1;
    lowcnt = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(1'b0, 1'b0, i >= 10);
      if (!bus_a.GSRNET) begin
        if (fall < 0) fall = i;
        lowcnt++;
      end
    end
    chk("gsrn_fall_latency", fall, 2);
    chk("gsrn_low_width", lowcnt, 13);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("mid_stretch_low", {31'd0, bus_a.GSRNET}, 32'd0);
    cyc(1'b1, 1'b0, 1'b1);
    chk("rst_mid_stretch", {28'd0, bus_a.PURNET, bus_a.GSRNET, bus_a.PUR_DONE, bus_a.GSR_ACTIVE}, 32'd0);
    pur_seq(0);
    burst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) burst = !burst;
      cyc($urandom_range(0, 149) == 0, $urandom_range(0, 11) == 0, !burst);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
